// File: rtl/reg_dump_reader.sv
// reg_dump_reader
//   Read-side companion to the CPU register bank. A Start pulse walks
//   register addresses 0..NUM_REGS-1 over the bank's combinational read port.
//   Each value is streamed out on a valid/ready handshake, tagged with its
//   index. Only the read port is used, so CPU writes keep going during a dump.
//
// Ports
//   Clock     in   system clock, rising edge
//   Reset     in   asynchronous, active-low reset
//   Start     in   pulse: begin a dump pass (ignored while Busy)
//   Abort     in   synchronous abort of the current pass (highest priority)
//   RdAddr    out  registered read address to the register bank
//   RdData    in   bank read data, combinational from RdAddr
//   OutValid  out  OutData/OutIndex valid
//   OutReady  in   consumer accepts the word when OutValid & OutReady
//   OutData   out  captured register value
//   OutIndex  out  register index of OutData
//   Busy      out  pass in progress
//   Done      out  one-cycle pulse after the last word is accepted
module reg_dump_reader #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Abort,
  output logic [ADDR_W-1:0] RdAddr,
  input  logic [DATA_W-1:0] RdData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutData,
  output logic [ADDR_W-1:0] OutIndex,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SEND
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state_reg, state_next;
  // The walking index doubles as the registered read address: both are
  // loaded and advanced together, so one register serves both roles.
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [DATA_W-1:0] out_data_reg, out_data_next;
  logic [ADDR_W-1:0] out_index_reg, out_index_next;
  logic              done_reg, done_next;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      out_data_reg  <= '0;
      out_index_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      out_data_reg  <= out_data_next;
      out_index_reg <= out_index_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    out_data_next  = out_data_reg;
    out_index_next = out_index_reg;
    done_next      = 1'b0;

    // Abort wins over everything, including a same-cycle Start in IDLE.
    // Captured data/index are deliberately left untouched.
    if (Abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Start) begin
            idx_next   = '0;
            state_next = ISSUE;
          end
        end
        ISSUE: begin
          // RdAddr has been stable for this whole cycle; sampling here means
          // a CPU write landing on this same edge is not seen.
          out_data_next  = RdData;
          out_index_next = idx_reg;
          state_next     = SEND;
        end
        SEND: begin
          if (OutReady) begin
            if (idx_reg == LAST_IDX) begin
              done_next  = 1'b1;
              state_next = IDLE;
            end else begin
              idx_next   = idx_reg + 1'b1;
              state_next = ISSUE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign RdAddr   = idx_reg;
  assign OutData  = out_data_reg;
  assign OutIndex = out_index_reg;
  assign OutValid = (state_reg == SEND);
  assign Busy     = (state_reg != IDLE);
  assign Done     = done_reg;

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              Start;
  logic              Abort;
  logic [ADDR_W-1:0] RdAddr;
  logic [DATA_W-1:0] RdData;
  logic              OutValid;
  logic              OutReady;
  logic [DATA_W-1:0] OutData;
  logic [ADDR_W-1:0] OutIndex;
  logic              Busy;
  logic              Done;

  always #5 Clock = ~Clock;

  reg_dump_reader #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Start   (Start),
    .Abort   (Abort),
    .RdAddr  (RdAddr),
    .RdData  (RdData),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .OutData (OutData),
    .OutIndex(OutIndex),
    .Busy    (Busy),
    .Done    (Done)
  );

  // Register bank: bulk preload or single CPU write, combinational read.
  logic [DATA_W-1:0] bank    [NUM_REGS];
  logic [DATA_W-1:0] preload [NUM_REGS];
  logic              load_en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  always @(posedge Clock) begin
    if (load_en) begin
      for (int i = 0; i < NUM_REGS; i++) bank[i] <= preload[i];
    end else if (wr_en) begin
      bank[wr_addr] <= wr_data;
    end
  end
  assign RdData = bank[RdAddr];

  // Reference model: what the registers hold, and the words a pass must emit.
  typedef struct {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic [DATA_W-1:0] model_regs [NUM_REGS];
  exp_t              exp_q [$];

  int checks = 0;
  int errors = 0;
  bit expect_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted word, checks Done follows
  // the last word by exactly one cycle.
  always @(negedge Clock) begin
    exp_t e;
    if (Reset !== 1'b1) begin
      expect_done = 1'b0;
    end else begin
      check("done_pulse", 32'(Done), 32'(expect_done));
      expect_done = 1'b0;
      if (OutValid && OutReady && !Abort) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(OutIndex), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          $display("word idx=%0d data=%h (expected idx=%0d data=%h)", OutIndex, OutData, e.idx, e.data);
          check("word_index", 32'(OutIndex), 32'(e.idx));
          check("word_data", 32'(OutData), 32'(e.data));
          if (e.idx == ADDR_W'(NUM_REGS - 1)) expect_done = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_bank(input bit randomize_data);
    for (int i = 0; i < NUM_REGS; i++) begin
      preload[i]    = randomize_data ? DATA_W'($urandom) : DATA_W'(16'hA000 + i);
      model_regs[i] = preload[i];
    end
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
  endtask

  // Start a pass from IDLE: every register is owed once, in index order.
  task automatic start_pass();
    Start = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) exp_q.push_back('{idx: ADDR_W'(i), data: model_regs[i]});
    tick();
    Start = 1'b0;
  endtask

  task automatic run_pass(input bit rand_ready);
    int n = 0;
    while (Busy && n < 2000) begin
      OutReady = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      n++;
    end
    OutReady = 1'b1;
    check("pass_finished", 32'(Busy), 32'd0);
    check("all_words_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_for_index(input int k);
    int n = 0;
    OutReady = 1'b1;
    while (!(OutValid && OutIndex == ADDR_W'(k)) && n < 200) begin
      tick();
      n++;
    end
    check("reached_index", 32'(OutIndex), 32'(k));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b0; Start = 1'b0; Abort = 1'b0; OutReady = 1'b1;
    load_en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #12;
    check("rst_rdaddr", 32'(RdAddr), 32'd0);
    check("rst_outvalid", 32'(OutValid), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_outdata", 32'(OutData), 32'd0);
    @(posedge Clock); #1;
    Reset = 1'b1;
    tick();

    // 1: full pass, ready always high, Done exactly in cycle 33.
    load_bank(1'b0);
    start_pass();
    for (int c = 1; c <= 34; c++) begin
      check("t1_done_cycle", 32'(Done), 32'(c == 2 * NUM_REGS + 1));
      tick();
    end
    check("t1_words", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // 2: back-pressure on idx 3 holds the word stable.
    start_pass();
    wait_for_index(3);
    OutReady = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t2_valid_held", 32'(OutValid), 32'd1);
      check("t2_data_held", 32'(OutData), 32'(model_regs[3]));
      check("t2_index_held", 32'(OutIndex), 32'd3);
      check("t2_rdaddr", 32'(RdAddr), 32'd3);
    end
    run_pass(1'b0);

    // 3: Start re-pulsed mid-pass is ignored.
    start_pass();
    wait_for_index(7);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    run_pass(1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t3_no_second_pass", 32'(Busy), 32'd0);
    end

    // 4: Abort in SEND at idx 9.
    start_pass();
    wait_for_index(9);
    OutReady = 1'b0;
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    check("t4_valid", 32'(OutValid), 32'd0);
    check("t4_busy", 32'(Busy), 32'd0);
    check("t4_done", 32'(Done), 32'd0);
    check("t4_words_left", 32'(exp_q.size()), 32'(NUM_REGS - 9));
    exp_q.delete();
    tick();
    check("t4_no_late_done", 32'(Done), 32'd0);
    start_pass();
    run_pass(1'b0);

    // Start and Abort together in IDLE: stay idle.
    Start = 1'b1; Abort = 1'b1;
    tick();
    Start = 1'b0; Abort = 1'b0;
    check("start_abort_idle", 32'(Busy), 32'd0);
    tick();
    check("start_abort_idle2", 32'(OutValid), 32'd0);

    // 5: CPU write to r5 during its ISSUE cycle (cycle 11) is not seen.
    start_pass();
    for (int c = 1; c < 11; c++) tick();
    check("t5_issue_idx5", 32'({Busy, OutValid, RdAddr}), 32'({1'b1, 1'b0, 4'd5}));
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234;
    tick();
    wr_en = 1'b0;
    model_regs[5] = 16'h1234;
    run_pass(1'b0);
    start_pass();
    run_pass(1'b0);

    // 6: asynchronous reset mid-pass at idx 6.
    start_pass();
    wait_for_index(6);
    OutReady = 1'b0;
    #1 Reset = 1'b0;
    #1;
    check("t6_rdaddr", 32'(RdAddr), 32'd0);
    check("t6_outvalid", 32'(OutValid), 32'd0);
    check("t6_outdata", 32'(OutData), 32'd0);
    check("t6_outindex", 32'(OutIndex), 32'd0);
    check("t6_busy", 32'(Busy), 32'd0);
    check("t6_done", 32'(Done), 32'd0);
    exp_q.delete();
    OutReady = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b1;
    tick();
    start_pass();
    run_pass(1'b0);

    // Randomized passes: random contents and random back-pressure.
    for (int p = 0; p < 4; p++) begin
      load_bank(1'b1);
      start_pass();
      run_pass(1'b1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
